// File: rtl/ps2_hex_entry_display.sv
// PS/2 keyboard hex-entry front end: frame receiver, make/break decoder, digit buffer
// and a multiplexed 7-segment scan driver.
module ps2_hex_entry_display #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned TIMEOUT_CYC    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              KeyClock,
    input  logic              KeyData,
    output logic [6:0]        LED_SEG,
    output logic [DIGITS-1:0] LED_VCC,
    output logic              key_valid,
    output logic [7:0]        key_code,
    output logic              frame_err
);

    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int          ND     = int'(DIGITS);
    localparam logic [6:0]  SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    typedef enum logic [1:0] {RxIdle, RxData, RxParity, RxStop} rx_state_t;
    typedef enum logic [1:0] {DecNormal, DecBreak, DecExt, DecExtBreak} dec_state_t;

    // Active-high segment pattern {G,F,E,D,C,B,A}.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    // Returns {valid, nibble}; valid = 0 for non-hex scan codes.
    function automatic logic [4:0] hex_lookup(input logic [7:0] c);
        case (c)
            8'h45: hex_lookup = 5'h10;
            8'h16: hex_lookup = 5'h11;
            8'h1E: hex_lookup = 5'h12;
            8'h26: hex_lookup = 5'h13;
            8'h25: hex_lookup = 5'h14;
            8'h2E: hex_lookup = 5'h15;
            8'h36: hex_lookup = 5'h16;
            8'h3D: hex_lookup = 5'h17;
            8'h3E: hex_lookup = 5'h18;
            8'h46: hex_lookup = 5'h19;
            8'h1C: hex_lookup = 5'h1A;
            8'h32: hex_lookup = 5'h1B;
            8'h21: hex_lookup = 5'h1C;
            8'h23: hex_lookup = 5'h1D;
            8'h24: hex_lookup = 5'h1E;
            8'h2B: hex_lookup = 5'h1F;
            default: hex_lookup = 5'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input logic [4:0] entry);
        if (!entry[4]) begin
            seg_of = SEG_BLANK;
        end else if (SEG_ACTIVE_LOW) begin
            seg_of = ~font(entry[3:0]);
        end else begin
            seg_of = font(entry[3:0]);
        end
    endfunction

    // ---------------------------------------------------------------- input sync
    logic [1:0] kc_sync;
    logic [1:0] kd_sync;
    logic       kc_last;
    logic       kc_fall;
    logic       kd;

    always_ff @(posedge clk) begin
        if (reset) begin
            kc_sync <= 2'b11;
            kd_sync <= 2'b11;
            kc_last <= 1'b1;
        end else begin
            kc_sync <= {kc_sync[0], KeyClock};
            kd_sync <= {kd_sync[0], KeyData};
            kc_last <= kc_sync[1];
        end
    end

    assign kc_fall = kc_last & ~kc_sync[1];
    assign kd      = kd_sync[1];

    // ---------------------------------------------------------------- receiver
    rx_state_t       rx_state;
    logic [7:0]      rx_shift;
    logic [2:0]      rx_bits;
    logic            rx_par;
    logic [TO_W-1:0] rx_timer;
    logic            code_strobe;
    logic [7:0]      code_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RxIdle;
            rx_shift    <= '0;
            rx_bits     <= '0;
            rx_par      <= 1'b0;
            rx_timer    <= '0;
            code_strobe <= 1'b0;
            code_byte   <= '0;
            frame_err   <= 1'b0;
        end else begin
            code_strobe <= 1'b0;
            frame_err   <= 1'b0;
            if (rx_state != RxIdle && !kc_fall && rx_timer == TO_W'(TIMEOUT_CYC - 1)) begin
                rx_state  <= RxIdle;
                rx_timer  <= '0;
                frame_err <= 1'b1;
            end else if (kc_fall) begin
                rx_timer <= '0;
                case (rx_state)
                    RxIdle: begin
                        if (!kd) begin
                            rx_state <= RxData;
                            rx_bits  <= '0;
                        end
                    end
                    RxData: begin
                        rx_shift <= {kd, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7) begin
                            rx_state <= RxParity;
                        end
                    end
                    RxParity: begin
                        rx_par   <= kd;
                        rx_state <= RxStop;
                    end
                    default: begin
                        rx_state <= RxIdle;
                        if (kd && (^{rx_shift, rx_par})) begin
                            code_strobe <= 1'b1;
                            code_byte   <= rx_shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end else if (rx_state != RxIdle) begin
                rx_timer <= rx_timer + TO_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- decoder + buffer
    dec_state_t dec_state;
    logic [4:0] digit_buf [DIGITS];
    logic [4:0] hex_entry;

    assign hex_entry = hex_lookup(code_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_state <= DecNormal;
            key_valid <= 1'b0;
            key_code  <= '0;
            for (int i = 0; i < ND; i++) begin
                digit_buf[i] <= '0;
            end
        end else begin
            key_valid <= 1'b0;
            if (code_strobe) begin
                unique case (dec_state)
                    DecNormal: begin
                        if (code_byte == CODE_BREAK) begin
                            dec_state <= DecBreak;
                        end else if (code_byte == CODE_EXT) begin
                            dec_state <= DecExt;
                        end else begin
                            key_valid <= 1'b1;
                            key_code  <= code_byte;
                            if (hex_entry[4]) begin
                                for (int i = ND - 1; i > 0; i--) begin
                                    digit_buf[i] <= digit_buf[i-1];
                                end
                                digit_buf[0] <= hex_entry;
                            end else if (code_byte == CODE_BKSP) begin
                                for (int i = 0; i < ND - 1; i++) begin
                                    digit_buf[i] <= digit_buf[i+1];
                                end
                                digit_buf[ND-1] <= '0;
                            end else if (code_byte == CODE_ESC) begin
                                for (int i = 0; i < ND; i++) begin
                                    digit_buf[i] <= '0;
                                end
                            end
                        end
                    end
                    DecBreak:    dec_state <= DecNormal;
                    DecExt:      dec_state <= (code_byte == CODE_BREAK) ? DecExtBreak : DecNormal;
                    DecExtBreak: dec_state <= DecNormal;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- scan driver
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  idx_next;
    logic              scan_tc;

    always_comb begin
        scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        idx_next = scan_idx;
        if (scan_tc) begin
            idx_next = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end
    end

    // Outputs are registered from the next index so segment and enable switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            LED_VCC  <= DIGITS'(1);
            LED_SEG  <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
            scan_idx <= idx_next;
            LED_VCC  <= DIGITS'(1) << idx_next;
            LED_SEG  <= seg_of(digit_buf[idx_next]);
        end
    end

endmodule

// File: tb/tb_ps2_hex_entry_display.sv
// Randomised bench for ps2_hex_entry_display against a key-sequence and scan model.
module tb_ps2_hex_entry_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int TIMEOUT  = 200;
    localparam int HALF     = 8;

    localparam logic [7:0] HEX_CODES [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h36, 8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
        7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [7:0] POOL [23] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h66, 8'h76,
        8'hF0, 8'hE0, 8'h75, 8'h5A, 8'h29};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              KeyClock = 1'b1;
    logic              KeyData = 1'b1;
    logic [6:0]        LED_SEG;
    logic [DIGITS-1:0] LED_VCC;
    logic              key_valid;
    logic [7:0]        key_code;
    logic              frame_err;

    ps2_hex_entry_display #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .TIMEOUT_CYC(TIMEOUT),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .KeyClock(KeyClock),
        .KeyData(KeyData),
        .LED_SEG(LED_SEG),
        .LED_VCC(LED_VCC),
        .key_valid(key_valid),
        .key_code(key_code),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model state: -1 marks a blank digit; mode 0..3 = normal, break, ext, ext-break.
    int         m_buf [DIGITS];
    int         m_mode = 0;
    int         m_kv = 0;
    logic [7:0] m_code = 8'h00;
    int         m_cnt = 0;
    int         m_idx = 0;
    int         kv_cnt = 0;
    int         fe_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0;
            m_idx = 0;
        end else if (m_cnt == SCAN_DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % DIGITS;
        end else begin
            m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] f;
        if (d < 0) return 7'h7F;
        f = FONT[d];
        return ~f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_buf[i] = -1;
        m_mode = 0;
        m_code = 8'h00;
    endtask

    task automatic model_code(input logic [7:0] c);
        int h;
        case (m_mode)
            0: begin
                if (c == 8'hF0) m_mode = 1;
                else if (c == 8'hE0) m_mode = 2;
                else begin
                    m_kv++;
                    m_code = c;
                    h = -1;
                    for (int i = 0; i < 16; i++) if (HEX_CODES[i] == c) h = i;
                    if (h >= 0) begin
                        for (int i = DIGITS - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                        m_buf[0] = h;
                    end else if (c == 8'h66) begin
                        for (int i = 0; i < DIGITS - 1; i++) m_buf[i] = m_buf[i+1];
                        m_buf[DIGITS-1] = -1;
                    end else if (c == 8'h76) begin
                        for (int i = 0; i < DIGITS; i++) m_buf[i] = -1;
                    end
                end
            end
            2: m_mode = (c == 8'hF0) ? 3 : 0;
            default: m_mode = 0;
        endcase
    endtask

    task automatic send_bits(input logic [10:0] fr, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            KeyData = fr[i];
            repeat (HALF) @(negedge clk);
            KeyClock = 1'b0;
            repeat (HALF) @(negedge clk);
            KeyClock = 1'b1;
        end
        KeyData = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] c, input bit bad_par,
                                               input bit bad_stop);
        return {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
    endfunction

    task automatic send_key(input logic [7:0] c);
        send_bits(make_frame(c, 1'b0, 1'b0), 0, 10);
        repeat (10) @(negedge clk);
        model_code(c);
        total++;
        if (kv_cnt !== m_kv) $display("FAIL key_valid count after %h: got %0d want %0d", c, kv_cnt, m_kv);
        else passed++;
        total++;
        if (key_code !== m_code) $display("FAIL key_code after %h: got %h want %h", c, key_code, m_code);
        else passed++;
    endtask

    task automatic check_display(input string name);
        for (int i = 0; i < DIGITS * SCAN_DIV + 1; i++) begin
            @(negedge clk);
            total++;
            if (LED_VCC !== DIGITS'(1 << m_idx))
                $display("FAIL %s LED_VCC: got %h want %h", name, LED_VCC, DIGITS'(1 << m_idx));
            else passed++;
            total++;
            if (LED_SEG !== exp_seg(m_buf[m_idx]))
                $display("FAIL %s LED_SEG digit %0d: got %h want %h", name, m_idx, LED_SEG,
                         exp_seg(m_buf[m_idx]));
            else passed++;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (LED_VCC !== DIGITS'(1)) $display("FAIL %s LED_VCC: got %h want 1", name, LED_VCC);
        else passed++;
        total++;
        if (LED_SEG !== 7'h7F) $display("FAIL %s LED_SEG: got %h want 7f", name, LED_SEG);
        else passed++;
        total++;
        if (key_valid !== 1'b0) $display("FAIL %s key_valid: got %b want 0", name, key_valid);
        else passed++;
        total++;
        if (key_code !== 8'h00) $display("FAIL %s key_code: got %h want 00", name, key_code);
        else passed++;
        total++;
        if (frame_err !== 1'b0) $display("FAIL %s frame_err: got %b want 0", name, frame_err);
        else passed++;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        check_display("reset_scan");
    endtask

    task automatic test_basic_entry();
        send_key(8'h16);
        send_key(8'h1E);
        send_key(8'h26);
        check_display("basic_entry");
    endtask

    task automatic test_break_ext();
        send_key(8'h16);
        send_key(8'hF0);
        send_key(8'h16);
        send_key(8'hE0);
        send_key(8'h75);
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        check_display("break_ext");
    endtask

    task automatic test_shift_edit();
        send_key(8'h16);
        send_key(8'h1E);
        send_key(8'h26);
        send_key(8'h25);
        send_key(8'h2E);
        check_display("shift_five");
        send_key(8'h66);
        check_display("backspace");
        send_key(8'h76);
        check_display("escape");
    endtask

    task automatic test_frame_errors();
        int fe0;
        fe0 = fe_cnt;
        send_bits(make_frame(8'h16, 1'b1, 1'b0), 0, 10);
        repeat (10) @(negedge clk);
        total++;
        if (fe_cnt !== fe0 + 1) $display("FAIL parity_err frame_err: got %0d want %0d", fe_cnt - fe0, 1);
        else passed++;
        total++;
        if (kv_cnt !== m_kv) $display("FAIL parity_err key_valid: got %0d want %0d", kv_cnt, m_kv);
        else passed++;
        send_bits(make_frame(8'h16, 1'b0, 1'b1), 0, 10);
        repeat (10) @(negedge clk);
        total++;
        if (fe_cnt !== fe0 + 2) $display("FAIL stop_err frame_err: got %0d want %0d", fe_cnt - fe0, 2);
        else passed++;
        send_key(8'h16);
        check_display("after_errors");
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        send_bits(make_frame(8'h3E, 1'b0, 1'b0), 0, 3);
        repeat (TIMEOUT + 10) @(negedge clk);
        total++;
        if (fe_cnt !== fe0 + 1) $display("FAIL timeout frame_err: got %0d want %0d", fe_cnt - fe0, 1);
        else passed++;
        send_key(8'h45);
        check_display("timeout_recover");
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] fr;
        fr = make_frame(8'h16, 1'b0, 1'b0);
        send_bits(fr, 0, 4);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        send_bits(fr, 5, 10);
        repeat (TIMEOUT + 20) @(negedge clk);
        total++;
        if (kv_cnt !== m_kv) $display("FAIL mid_reset key_valid: got %0d want %0d", kv_cnt, m_kv);
        else passed++;
        check_display("mid_reset_scan");
    endtask

    task automatic test_random();
        int fe0;
        fe0 = fe_cnt;
        for (int n = 0; n < 40; n++) begin
            send_key(POOL[$urandom_range(0, 22)]);
            if (n % 8 == 7) check_display("random");
        end
        total++;
        if (fe_cnt !== fe0) $display("FAIL random frame_err: got %0d want 0", fe_cnt - fe0);
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_entry();
        test_break_ext();
        test_shift_edit();
        test_frame_errors();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
